// File: rtl/game_screen_ctrl_if.sv
// Signal bundle between the board-facing pager controller and its user:
// raw switch/buttons and auto-advance enable in, screen index and status out.
interface game_screen_ctrl_if;
  logic       sw;
  logic       btnR;
  logic       btnL;
  logic       auto_en;
  logic [3:0] screen;
  logic       active;
  logic       changed;

  modport master (
    output sw, btnR, btnL, auto_en,
    input  screen, active, changed
  );

  modport slave (
    input  sw, btnR, btnL, auto_en,
    output screen, active, changed
  );
endinterface

// File: rtl/game_screen_ctrl.sv
// Game screen pager: synchronises and debounces the board buttons, turns each
// debounced rising edge into a single screen step (with wrap-around), and
// optionally auto-advances on a slideshow timer while the game switch is on.
module game_screen_ctrl #(
  parameter int NUM_SCREENS     = 11,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int AUTO_CYCLES     = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  game_screen_ctrl_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(AUTO_CYCLES);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST    = TW'(AUTO_CYCLES - 1);
  localparam logic [3:0]    LAST_SCREEN = 4'(NUM_SCREENS);
  localparam logic [3:0]    FIRST_SCREEN = 4'd1;

  typedef enum logic {IDLE, RUN} state_t;

  // Button vectors: bit 0 = btnR (next), bit 1 = btnL (previous).
  localparam int BR = 0;
  localparam int BL = 1;

  logic                  sw_s1_q, sw_s2_q;
  logic [1:0]            btn_s1_q, btn_s2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            deb_dly_q;
  logic [1:0][DW-1:0]    deb_cnt_q, deb_cnt_d;
  logic [1:0]            press;

  state_t                state_q, state_d;
  logic [3:0]            screen_q, screen_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  active_q, active_d;
  logic                  changed_q, changed_d;

  logic [3:0]            screen_next;
  logic [3:0]            screen_prev;

  // Debounce: the level only follows the synced input after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (btn_s2_q[i] == deb_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        deb_d[i]     = btn_s2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  // One pulse per debounced press; releases are ignored.
  assign press       = deb_q & ~deb_dly_q;
  assign screen_next = (screen_q == LAST_SCREEN)  ? FIRST_SCREEN : screen_q + 4'd1;
  assign screen_prev = (screen_q == FIRST_SCREEN) ? LAST_SCREEN  : screen_q - 4'd1;

  // Next-state logic: switch first, then simultaneous presses, R, L, auto tick.
  always_comb begin
    state_d  = state_q;
    screen_d = screen_q;
    timer_d  = timer_q;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (sw_s2_q) begin
          state_d  = RUN;
          screen_d = FIRST_SCREEN;
        end
      end
      RUN: begin
        if (!sw_s2_q) begin
          state_d  = IDLE;
          screen_d = '0;
          timer_d  = '0;
        end else if (press[BR] && press[BL]) begin
          timer_d = '0;
        end else if (press[BR]) begin
          screen_d = screen_next;
          timer_d  = '0;
        end else if (press[BL]) begin
          screen_d = screen_prev;
          timer_d  = '0;
        end else if (bus.auto_en && timer_q == TMR_LAST) begin
          screen_d = screen_next;
          timer_d  = '0;
        end else if (bus.auto_en) begin
          timer_d = timer_q + 1'b1;
        end else begin
          timer_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        screen_d = '0;
        timer_d  = '0;
      end
    endcase
    active_d  = (state_d == RUN);
    changed_d = (screen_d != screen_q);
  end

  // All state: synchronisers, debouncers, FSM and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      sw_s1_q   <= 1'b0;
      sw_s2_q   <= 1'b0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      deb_cnt_q <= '0;
      state_q   <= IDLE;
      screen_q  <= '0;
      timer_q   <= '0;
      active_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sw_s1_q   <= bus.sw;
      sw_s2_q   <= sw_s1_q;
      btn_s1_q  <= {bus.btnL, bus.btnR};
      btn_s2_q  <= btn_s1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      screen_q  <= screen_d;
      timer_q   <= timer_d;
      active_q  <= active_d;
      changed_q <= changed_d;
    end
  end

  assign bus.screen  = screen_q;
  assign bus.active  = active_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Bench for game_screen_ctrl: directed scenarios followed by random stimulus,
// every cycle compared with a timestamp/history based reference model.
module tb_game_screen_ctrl;
  localparam int NS = 11;
  localparam int DB = 4;
  localparam int AC = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_screen_ctrl_if bus ();

  game_screen_ctrl #(
    .NUM_SCREENS    (NS),
    .DEBOUNCE_CYCLES(DB),
    .AUTO_CYCLES    (AC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state. Raw inputs sampled at each edge are kept newest
  // first; the synchronised view lags raw samples by two edges.
  bit hsw[$];
  bit hr[$];
  bit hl[$];
  bit m_deb_r, m_deb_l, m_dly_r, m_dly_l;
  bit m_run, m_changed;
  int m_screen;
  int t_zero;   // edge at which the slideshow timer was last set to zero

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hsw.delete(); hr.delete(); hl.delete();
    for (int j = 0; j < DB + 2; j++) begin
      hsw.push_back(1'b0); hr.push_back(1'b0); hl.push_back(1'b0);
    end
    m_deb_r = 0; m_deb_l = 0; m_dly_r = 0; m_dly_l = 0;
    m_run = 0; m_changed = 0; m_screen = 0; t_zero = cyc;
  endtask

  // Debounced level flips once the last DB synced samples all disagree with it.
  function automatic bit flips(input bit h[$], input bit deb);
    for (int j = 1; j <= DB; j++)
      if (h[j] == deb) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit sw_in, input bit r_in, input bit l_in,
                            input bit ae, input bit rst_in);
    bit sw_sync, pr, pl, fr, fl;
    int prev, timer_pre;
    if (rst_in) begin
      model_reset();
      return;
    end
    sw_sync   = hsw[1];
    pr        = m_deb_r && !m_dly_r;
    pl        = m_deb_l && !m_dly_l;
    timer_pre = cyc - 1 - t_zero;
    fr        = flips(hr, m_deb_r);
    fl        = flips(hl, m_deb_l);
    prev      = m_screen;
    if (!m_run) begin
      if (sw_sync) begin m_run = 1; m_screen = 1; end
      t_zero = cyc;
    end else if (!sw_sync) begin
      m_run = 0; m_screen = 0; t_zero = cyc;
    end else if (pr && pl) begin
      t_zero = cyc;
    end else if (pr) begin
      m_screen = m_screen % NS + 1; t_zero = cyc;
    end else if (pl) begin
      m_screen = (m_screen + NS - 2) % NS + 1; t_zero = cyc;
    end else if (ae && timer_pre == AC - 1) begin
      m_screen = m_screen % NS + 1; t_zero = cyc;
    end else if (!ae) begin
      t_zero = cyc;
    end
    m_changed = (m_screen != prev);
    m_dly_r = m_deb_r; if (fr) m_deb_r = !m_deb_r;
    m_dly_l = m_deb_l; if (fl) m_deb_l = !m_deb_l;
    hsw.push_front(sw_in); void'(hsw.pop_back());
    hr.push_front(r_in);   void'(hr.pop_back());
    hl.push_front(l_in);   void'(hl.pop_back());
  endtask

  // One clock edge: advance the model with the sampled inputs, then compare
  // all outputs at the following falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge(bus.sw, bus.btnR, bus.btnL, bus.auto_en, rst);
    @(negedge clk);
    check("model_screen",  32'(bus.screen),  32'(m_screen));
    check("model_active",  32'(bus.active),  32'(m_run));
    check("model_changed", 32'(bus.changed), 32'(m_changed));
  endtask

  task automatic press_btn(input bit r, input bit l);
    bus.btnR = r; bus.btnL = l;
    repeat (8) tick();
    bus.btnR = 0; bus.btnL = 0;
    repeat (8) tick();
  endtask

  initial begin
    int ch;
    bus.sw = 0; bus.btnR = 0; bus.btnL = 0; bus.auto_en = 0;
    rst = 1;
    model_reset();

    // Reset state and switch-on latency.
    tick(); tick();
    check("rst_screen",  32'(bus.screen),  0);
    check("rst_active",  32'(bus.active),  0);
    check("rst_changed", 32'(bus.changed), 0);
    rst = 0; bus.sw = 1;
    tick(); check("sw_e1_screen", 32'(bus.screen), 0);
    tick(); check("sw_e2_screen", 32'(bus.screen), 0);
    tick();
    check("sw_e3_screen",  32'(bus.screen),  1);
    check("sw_e3_active",  32'(bus.active),  1);
    check("sw_e3_changed", 32'(bus.changed), 1);
    tick(); check("sw_e4_changed", 32'(bus.changed), 0);

    // Press latency, hold gives one step, re-press steps again.
    repeat (3) tick();
    bus.btnR = 1;
    repeat (6) tick();
    check("r_e6_screen", 32'(bus.screen), 1);
    tick();
    check("r_e7_screen",  32'(bus.screen),  2);
    check("r_e7_changed", 32'(bus.changed), 1);
    repeat (100) tick();
    check("r_hold_screen", 32'(bus.screen), 2);
    bus.btnR = 0; repeat (10) tick();
    bus.btnR = 1; repeat (7) tick();
    check("r_repress_screen", 32'(bus.screen), 3);
    bus.btnR = 0; repeat (10) tick();

    // Bounce shorter than the debounce window is ignored.
    ch = 0;
    for (int p = 0; p < 4; p++) begin
      bus.btnR = (p % 2 == 0);
      repeat (2) begin tick(); ch += int'(bus.changed); end
    end
    bus.btnR = 0;
    repeat (10) begin tick(); ch += int'(bus.changed); end
    check("bounce_changed_count", 32'(ch), 0);
    check("bounce_screen", 32'(bus.screen), 3);

    // Wrap-around both ways and simultaneous presses.
    repeat (8) press_btn(1, 0);
    check("up_to_max", 32'(bus.screen), NS);
    press_btn(1, 0); check("wrap_up",   32'(bus.screen), 1);
    press_btn(0, 1); check("wrap_down", 32'(bus.screen), NS);
    press_btn(1, 1); check("both_pressed", 32'(bus.screen), NS);
    press_btn(1, 0); check("back_to_1", 32'(bus.screen), 1);

    // Slideshow timing, and a manual press coinciding with an auto tick.
    bus.auto_en = 1;
    repeat (19) tick(); check("auto_e19", 32'(bus.screen), 1);
    tick();             check("auto_e20", 32'(bus.screen), 2);
    repeat (19) tick(); check("auto_e39", 32'(bus.screen), 2);
    tick();             check("auto_e40", 32'(bus.screen), 3);
    repeat (13) tick();
    bus.btnR = 1;
    repeat (6) tick();  check("coinc_e59", 32'(bus.screen), 3);
    tick();             check("coinc_e60", 32'(bus.screen), 4);
    repeat (19) tick(); check("coinc_e79", 32'(bus.screen), 4);
    tick();             check("coinc_e80", 32'(bus.screen), 5);
    bus.btnR = 0; bus.auto_en = 0;
    repeat (10) tick();

    // Switch off while a press is debouncing: press dropped.
    bus.btnR = 1;
    tick(); tick();
    bus.sw = 0;
    repeat (3) tick();
    check("swoff_screen", 32'(bus.screen), 0);
    check("swoff_active", 32'(bus.active), 0);
    repeat (5) tick();
    check("swoff_dropped", 32'(bus.screen), 0);
    bus.sw = 1;
    repeat (3) tick();
    check("swon_screen", 32'(bus.screen), 1);
    bus.btnR = 0; repeat (10) tick();
    repeat (6) press_btn(1, 0);
    check("pre_rst_screen", 32'(bus.screen), 7);
    rst = 1;
    tick();
    check("midrst_screen",  32'(bus.screen),  0);
    check("midrst_active",  32'(bus.active),  0);
    check("midrst_changed", 32'(bus.changed), 0);
    rst = 0;
    repeat (5) tick();

    // Random stimulus against the reference model.
    for (int s = 0; s < 300; s++) begin
      bus.btnR    = 1'($urandom_range(0, 1));
      bus.btnL    = ($urandom_range(0, 3) == 0);
      bus.sw      = ($urandom_range(0, 19) != 0);
      bus.auto_en = 1'($urandom_range(0, 1));
      rst         = ($urandom_range(0, 99) == 0);
      repeat ($urandom_range(1, 12)) tick();
      rst = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
